btn_debounce_fsm: RTL
=====================

// Module: btn_debounce_fsm
// PURPOSE
//  Push-button debouncer fed by the slow divided tick from the debounce clock divider.
//  Synchronises the raw button and the divider tick into clk, samples the button once per tick,
//  and declares a press/release only after STABLE_TICKS consecutive agreeing samples.
//  Emits a clean level plus 1-cycle press/release pulses for the counter/adder datapath.
// PARAMETERS
//  STABLE_TICKS  4   consecutive agreeing samples to change state; legal 2..15
//  BTN_ACT_LOW   1   1: btn_raw low = pressed; 0: btn_raw high = pressed
//  REPEAT_DELAY  32  ticks held before first auto-repeat pulse (DB_AUTOREPEAT_EN only); 2..255
//  REPEAT_RATE   8   ticks between later auto-repeat pulses (DB_AUTOREPEAT_EN only); 1..255
// PORTS
//  clk          in   1  system clock; only clock in the block
//  rst          in   1  reset: synchronous, active-high
//  tick_in      in   1  divided-clock level from divider (async to clk); rising edge = sample point
//  btn_raw      in   1  raw, bouncing button pin (async)
//  btn_level    out  1  debounced state, 1 = pressed
//  btn_press    out  1  1-cycle pulse on debounced press (and auto-repeat if enabled)
//  btn_release  out  1  1-cycle pulse on debounced release
// BEHAVIOUR
//  - Reset (rst=1 at posedge clk): all syncs, counters, FSM -> released/0; btn_level=btn_press=btn_release=0.
//  - Sync: btn_raw -> 2 FFs -> normalise (invert if BTN_ACT_LOW) -> pr (1 = pressed).
//    tick_in -> 3 FFs t1,t2,t3; sample_en = t2 & ~t3 (combinational, exactly 1 clk per tick rise).
//  - FSM (2-bit), cnt (4-bit) advance only on sample_en cycles; otherwise hold.
//    S_REL:   btn_level=0. sample_en & pr -> cnt=1, S_PWAIT. sample_en & ~pr -> stay, cnt=0.
//    S_PWAIT: sample_en & pr -> cnt+1; when cnt+1==STABLE_TICKS -> S_PRS, cnt=0.
//             sample_en & ~pr -> S_REL, cnt=0 (bounce rejected, no pulse).
//    S_PRS:   btn_level=1. sample_en & ~pr -> cnt=1, S_RWAIT.
//    S_RWAIT: sample_en & ~pr -> cnt+1; at STABLE_TICKS -> S_REL, cnt=0.
//             sample_en & pr -> S_PRS, cnt=0 (no pulse, btn_level stays 1).
//  - Outputs registered: btn_press=1 and btn_level rises in the cycle after the qualifying
//    sample_en (the STABLE_TICKS-th consecutive pressed sample); btn_release/level-fall likewise.
//  - Latency pin->pr: 2 clk. tick_in rise->sample_en: 2 clk (t2 set). No pulse while rst=1.
//  - btn_press and btn_release never high in the same cycle; each pulse exactly 1 clk wide.
//  - Reset mid-press: FSM restarts in S_REL; a still-held button is re-qualified and yields a
//    fresh btn_press after STABLE_TICKS samples.
//  - tick_in stuck (divider held in reset): no sample_en, FSM and outputs frozen.
//  - cnt cannot wrap: always cleared on state change; STABLE_TICKS<=15 fits 4 bits.
// CONFIGURATION
//  DB_AUTOREPEAT_EN defined: 8-bit rcnt counts sample_en in S_PRS/S_RWAIT (cleared on entering
//    S_PRS from S_PWAIT, held during S_RWAIT, cleared on S_REL). Extra btn_press pulse at
//    rcnt==REPEAT_DELAY, then every REPEAT_RATE ticks, rcnt saturates/reloads, never wraps.
//    Repeats stop the cycle S_REL is entered; no repeat coincides with btn_release.
//  DB_AUTOREPEAT_EN undefined: rcnt absent; exactly one btn_press per debounced press.
// TESTING  (STABLE_TICKS=4, BTN_ACT_LOW=1, tick_in period 8 clk unless stated)
//  1 rst=1 3 clk, btn_raw=1, tick running -> all outputs 0; after release of rst, no pulses.
//  2 btn_raw=0 held clean -> exactly one btn_press, 1 clk wide, one clk after 4th sample_en;
//    btn_level=1 from same cycle; btn_release stays 0.
//  3 btn_raw toggles 0/1 each tick for 10 ticks, then 1 -> no pulses, btn_level stays 0.
//  4 pressed state, btn_raw=1 for 3 ticks then 0 -> no btn_release, btn_level stays 1;
//    then 1 for 4 ticks -> one btn_release, btn_level=0.
//  5 press held, rst pulsed 1 clk mid-hold -> outputs 0 next clk; btn_press again after 4 ticks.
//  6 DB_AUTOREPEAT_EN, REPEAT_DELAY=4, REPEAT_RATE=2, hold 12 ticks after qualification ->
//    btn_press at qualification, then at ticks 4,6,8,10,12; none after btn_release.

Source files
------------

// File: rtl/btn_debounce_fsm.sv
// btn_debounce_fsm: debounces a raw push-button, sampling it once per rising edge of a slow divider tick.
// Latency: pin->pr 2 clk, tick rise->sample_en 2 clk, btn_level/btn_press/btn_release registered 1 clk after the qualifying sample.
// No backpressure: pulses are single-cycle and never held; define DB_AUTOREPEAT_EN to add auto-repeat btn_press pulses.
module btn_debounce_fsm #(
   parameter int unsigned STABLE_TICKS = 4,   // consecutive agreeing samples, 2..15
   parameter int unsigned BTN_ACT_LOW  = 1,   // 1: pin low = pressed
   parameter int unsigned REPEAT_DELAY = 32,  // ticks held before first repeat, 2..255
   parameter int unsigned REPEAT_RATE  = 8    // ticks between later repeats, 1..255
) (
   input  logic clk,
   input  logic rst,
   input  logic tick_in,
   input  logic btn_raw,
   output logic btn_level,
   output logic btn_press,
   output logic btn_release
);

   localparam logic [1:0] S_REL   = 2'd0;
   localparam logic [1:0] S_PWAIT = 2'd1;
   localparam logic [1:0] S_PRS   = 2'd2;
   localparam logic [1:0] S_RWAIT = 2'd3;

   localparam logic [3:0] STABLE_CNT = 4'(STABLE_TICKS);
   // Pin level of a released button; syncs reset here so pr reads "released" out of reset.
   localparam logic       REL_PIN    = (BTN_ACT_LOW != 0);

   // Synchroniser flops
   logic       btn_s1_q, btn_s1_d;
   logic       btn_s2_q, btn_s2_d;
   logic       tick_s1_q, tick_s1_d;
   logic       tick_s2_q, tick_s2_d;
   logic       tick_s3_q, tick_s3_d;

   // FSM and output flops
   logic [1:0] state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       level_q, level_d;
   logic       press_q, press_d;
   logic       release_q, release_d;

   logic       pr;          // synchronised, normalised button: 1 = pressed
   logic       sample_en;   // one clk per tick rising edge
   logic [3:0] cnt_inc;
   logic       press_fsm;   // debounced press qualified this cycle
   logic       rep_fire;    // auto-repeat press this cycle

   // Two-flop sync of the pin, three-flop sync of the tick so its edge can be detected safely
   always_comb begin
      btn_s1_d  = btn_raw;
      btn_s2_d  = btn_s1_q;
      tick_s1_d = tick_in;
      tick_s2_d = tick_s1_q;
      tick_s3_d = tick_s2_q;
      pr        = (BTN_ACT_LOW != 0) ? ~btn_s2_q : btn_s2_q;
      sample_en = tick_s2_q & ~tick_s3_q;
   end

   // Debounce FSM: only a sample_en cycle may move the state or the agreement counter
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      press_fsm = 1'b0;
      release_d = 1'b0;
      cnt_inc   = cnt_q + 4'd1;
      if (sample_en) begin
         case (state_q)
            S_REL: begin
               if (pr) begin
                  state_d = S_PWAIT;
                  cnt_d   = 4'd1;
               end else begin
                  cnt_d   = 4'd0;
               end
            end
            S_PWAIT: begin
               if (pr) begin
                  if (cnt_inc == STABLE_CNT) begin
                     state_d   = S_PRS;
                     cnt_d     = 4'd0;
                     press_fsm = 1'b1;
                  end else begin
                     cnt_d     = cnt_inc;
                  end
               end else begin
                  // bounce: give up quietly
                  state_d = S_REL;
                  cnt_d   = 4'd0;
               end
            end
            S_PRS: begin
               if (!pr) begin
                  state_d = S_RWAIT;
                  cnt_d   = 4'd1;
               end else begin
                  cnt_d   = 4'd0;
               end
            end
            S_RWAIT: begin
               if (!pr) begin
                  if (cnt_inc == STABLE_CNT) begin
                     state_d   = S_REL;
                     cnt_d     = 4'd0;
                     release_d = 1'b1;
                  end else begin
                     cnt_d     = cnt_inc;
                  end
               end else begin
                  // release glitch: back to pressed, level never dropped
                  state_d = S_PRS;
                  cnt_d   = 4'd0;
               end
            end
            default: begin
               state_d = S_REL;
               cnt_d   = 4'd0;
            end
         endcase
      end
   end

`ifdef DB_AUTOREPEAT_EN
   localparam logic [7:0] DELAY_CNT = 8'(REPEAT_DELAY);
   localparam logic [7:0] RATE_CNT  = 8'(REPEAT_RATE);

   logic [7:0] rcnt_q, rcnt_d;
   logic       rphase_q, rphase_d;  // 0: waiting for first repeat, 1: repeating at RATE
   logic [7:0] rcnt_inc;
   logic [7:0] rtarget;

   // Repeat timer: counts pressed samples while settled in S_PRS; a pending release
   // (S_RWAIT) freezes it, and entering S_REL clears it so no repeat can meet btn_release.
   always_comb begin
      rcnt_d   = rcnt_q;
      rphase_d = rphase_q;
      rep_fire = 1'b0;
      rcnt_inc = rcnt_q + 8'd1;
      rtarget  = rphase_q ? RATE_CNT : DELAY_CNT;
      if (state_d == S_REL) begin
         rcnt_d   = 8'd0;
         rphase_d = 1'b0;
      end else if (sample_en && (state_q == S_PWAIT) && (state_d == S_PRS)) begin
         rcnt_d   = 8'd0;
         rphase_d = 1'b0;
      end else if (sample_en && (state_q == S_PRS) && (state_d == S_PRS)) begin
         // counter restarts at each repeat, so it stays below its target and never wraps
         if (rcnt_inc == rtarget) begin
            rep_fire = 1'b1;
            rcnt_d   = 8'd0;
            rphase_d = 1'b1;
         end else begin
            rcnt_d   = rcnt_inc;
         end
      end
   end

   // Repeat timer state
   always_ff @(posedge clk) begin
      if (rst) begin
         rcnt_q   <= 8'd0;
         rphase_q <= 1'b0;
      end else begin
         rcnt_q   <= rcnt_d;
         rphase_q <= rphase_d;
      end
   end
`else
   logic unused_repeat_cfg;
   assign unused_repeat_cfg = ^{8'(REPEAT_DELAY), 8'(REPEAT_RATE)};
   assign rep_fire = 1'b0;
`endif

   // Registered outputs: level follows the next state, press merges debounce and repeat pulses
   always_comb begin
      level_d = (state_d == S_PRS) || (state_d == S_RWAIT);
      press_d = press_fsm | rep_fire;
   end

   // All state registers with synchronous reset to the released condition
   always_ff @(posedge clk) begin
      if (rst) begin
         btn_s1_q  <= REL_PIN;
         btn_s2_q  <= REL_PIN;
         tick_s1_q <= 1'b0;
         tick_s2_q <= 1'b0;
         tick_s3_q <= 1'b0;
         state_q   <= S_REL;
         cnt_q     <= 4'd0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         btn_s1_q  <= btn_s1_d;
         btn_s2_q  <= btn_s2_d;
         tick_s1_q <= tick_s1_d;
         tick_s2_q <= tick_s2_d;
         tick_s3_q <= tick_s3_d;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

   assign btn_level   = level_q;
   assign btn_press   = press_q;
   assign btn_release = release_q;

endmodule
